// File: rtl/blit_queue.sv
// rtl/blit_queue.sv - blit command FIFO and one-at-a-time dispatch sequencer
// Optional build macro BLIT_QUEUE_COLL_STICKY_EN adds coll_clr / coll_sticky.
module blit_queue #(
  parameter int DEPTH = 4,
  localparam int LVLW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [11:0]     cmd_src,
  input  logic [3:0]      cmd_height,
  input  logic [6:0]      cmd_x,
  input  logic [5:0]      cmd_y,
  output logic [2:0]      blit_operation,
  output logic [11:0]     blit_src,
  output logic [3:0]      blit_height,
  output logic [6:0]      blit_x,
  output logic [5:0]      blit_y,
  output logic            blit_enable,
  input  logic            blit_ready,
  input  logic            blit_collision,
  output logic            done,
  output logic            done_collision,
  output logic            busy,
`ifdef BLIT_QUEUE_COLL_STICKY_EN
  input  logic            coll_clr,
  output logic            coll_sticky,
`endif
  output logic [LVLW-1:0] level
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_RELEASE
  } state_t;

  state_t          state;
  logic [31:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LVLW-1:0] count;
  logic            push;
  logic            pop;

  // A full queue refuses pushes even when a pop happens in the same cycle.
  assign cmd_ready = (count != LVLW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign level     = count;
  assign busy      = (count != '0) || (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_src, cmd_height, cmd_x, cmd_y};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // blit_* fields only load in IDLE, so they hold from enable rise through done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      blit_operation <= '0;
      blit_src       <= '0;
      blit_height    <= '0;
      blit_x         <= '0;
      blit_y         <= '0;
      blit_enable    <= 1'b0;
      done           <= 1'b0;
      done_collision <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            {blit_operation, blit_src, blit_height, blit_x, blit_y} <= mem[rd_ptr];
            blit_enable <= 1'b1;
            state       <= S_START;
          end
        end
        S_START: begin
          if (!blit_ready) state <= S_RUN;
        end
        S_RUN: begin
          if (blit_ready) begin
            done_collision <= blit_collision;
            done           <= 1'b1;
            blit_enable    <= 1'b0;
            state          <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BLIT_QUEUE_COLL_STICKY_EN
  // Set wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_sticky <= 1'b0;
    end else if (done && done_collision) begin
      coll_sticky <= 1'b1;
    end else if (coll_clr) begin
      coll_sticky <= 1'b0;
    end
  end
`endif

endmodule
